// File: rtl/axis_cnt_gen.sv
// AXI-Stream counting packet generator: emits fixed-length packets of an
// incrementing or constant payload with an optional idle gap between packets.
module axis_cnt_gen #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PKT_LEN   = 8,
   parameter int unsigned GAP       = 0,
   parameter int unsigned MODE      = 0,
   parameter logic [63:0] START     = 64'd0,
   parameter logic [63:0] CONST_VAL = 64'd5555
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic              pkt_done,
   output logic [1:0]        o_dbg_state
);

   // Stream handshake: a beat transfers on every rising edge where m_tvalid
   // and m_tready are both 1; while m_tvalid is 1 and the beat is not taken,
   // m_tdata/m_tlast are held and m_tvalid stays asserted.

   localparam int unsigned IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_LEN - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
   localparam logic [DATA_W-1:0] INIT_DATA = (MODE == 1) ? CONST_VAL[DATA_W-1:0]
                                                         : START[DATA_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [IDX_W-1:0]   r_idx;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [DATA_W-1:0]  r_data;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic [CNT_W-1:0]   r_pkt_cnt;
   logic               r_pkt_done;
   logic               w_accept;
   logic               w_last;
   logic               w_pkt_end;

   assign w_last    = (r_idx == LAST_IDX);
   assign w_accept  = m_tvalid & m_tready;
   assign w_pkt_end = w_accept & w_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // en is only consulted where a packet could start: in IDLE, on the tlast
   // accept when there is no gap, and on the final HOLD cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (en) w_next_state = S_SEND;
         end
         S_SEND: begin
            if (w_pkt_end) begin
               if (GAP > 0)  w_next_state = S_HOLD;
               else if (!en) w_next_state = S_IDLE;
            end
         end
         S_HOLD: begin
            if (r_gap_cnt == '0) w_next_state = en ? S_SEND : S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_gap_cnt  <= '0;
         r_data     <= INIT_DATA;
         r_beat_cnt <= '0;
         r_pkt_cnt  <= '0;
         r_pkt_done <= 1'b0;
      end else begin
         r_pkt_done <= w_pkt_end;
         if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
            if (MODE == 0) r_data <= r_data + DATA_W'(1);
         end
         if (w_pkt_end) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
         end
         // Loaded with GAP-1 so that HOLD lasts exactly GAP cycles.
         if (w_pkt_end) begin
            r_gap_cnt <= GAP_LOAD;
         end else if (r_state == S_HOLD && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
         end
      end
   end

   assign m_tvalid    = (r_state == S_SEND);
   assign m_tlast     = m_tvalid & w_last;
   assign m_tdata     = r_data;
   assign beat_cnt    = r_beat_cnt;
   assign pkt_cnt     = r_pkt_cnt;
   assign pkt_done    = r_pkt_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_cnt_gen.sv
// Bench for axis_cnt_gen: four differently parameterised instances share the
// stimulus; a per-cycle stream model plus directed scenario checks.
module tb_axis_cnt_gen;

   localparam int NI = 4;
   localparam int P_W     [NI] = '{16, 16, 4, 16};
   localparam int P_LEN   [NI] = '{8, 4, 4, 1};
   localparam int P_GAP   [NI] = '{0, 3, 0, 1};
   localparam int P_MODE  [NI] = '{0, 0, 0, 1};
   localparam int P_START [NI] = '{0, 0, 14, 0};
   localparam longint unsigned CONST_DEF = 64'd5555;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic m_tready;

   logic [15:0] mon_data  [NI];
   logic        mon_valid [NI];
   logic        mon_last  [NI];
   logic        mon_done  [NI];
   logic [31:0] mon_bcnt  [NI];
   logic [31:0] mon_pcnt  [NI];
   logic [1:0]  mon_state [NI];

   int n_tests = 0;
   int n_fail  = 0;

   // stream model state, one slot per instance
   bit           mon_on = 1'b0;
   int unsigned  k_beats    [NI];
   int unsigned  k_pkts     [NI];
   bit           exp_valid  [NI];
   bit           exp_done   [NI];
   bit           prev_stall [NI];
   logic [15:0]  prev_data  [NI];
   logic         prev_last  [NI];
   int           gap_left   [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = P_W[g];
      logic [W-1:0] w_data;
      logic         w_valid;
      logic         w_last;
      logic         w_done;
      logic [31:0]  w_bcnt;
      logic [31:0]  w_pcnt;
      logic [1:0]   w_state;

      axis_cnt_gen #(
         .DATA_W   (W),
         .CNT_W    (32),
         .PKT_LEN  (P_LEN[g]),
         .GAP      (P_GAP[g]),
         .MODE     (P_MODE[g]),
         .START    (64'(P_START[g])),
         .CONST_VAL(64'(CONST_DEF))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .en         (en),
         .m_tdata    (w_data),
         .m_tvalid   (w_valid),
         .m_tready   (m_tready),
         .m_tlast    (w_last),
         .beat_cnt   (w_bcnt),
         .pkt_cnt    (w_pcnt),
         .pkt_done   (w_done),
         .o_dbg_state(w_state)
      );

      assign mon_data[g]  = 16'(w_data);
      assign mon_valid[g] = w_valid;
      assign mon_last[g]  = w_last;
      assign mon_done[g]  = w_done;
      assign mon_bcnt[g]  = w_bcnt;
      assign mon_pcnt[g]  = w_pcnt;
      assign mon_state[g] = w_state;
   end

   function automatic logic [15:0] exp_data(int i, int unsigned k);
      longint unsigned v;
      v = (P_MODE[i] == 1) ? CONST_DEF : (64'(P_START[i]) + 64'(k));
      return 16'(v & ((64'd1 << P_W[i]) - 64'd1));
   endfunction

   // Called at a falling edge: checks the outputs now visible against the
   // model, then advances the model by what the next rising edge will do.
   task automatic monitor();
      bit acc;
      bit mlast;
      for (int i = 0; i < NI; i++) begin
         mlast = ((k_beats[i] % P_LEN[i]) == P_LEN[i] - 1);
         if (mon_on) begin
            n_tests++;
            if (mon_valid[i] !== exp_valid[i]) begin
               n_fail++;
               $display("FAIL tvalid inst%0d t=%0t: got %b expected %b", i, $time, mon_valid[i], exp_valid[i]);
            end
            n_tests++;
            if (mon_done[i] !== exp_done[i]) begin
               n_fail++;
               $display("FAIL pkt_done inst%0d t=%0t: got %b expected %b", i, $time, mon_done[i], exp_done[i]);
            end
            n_tests++;
            if (mon_bcnt[i] !== 32'(k_beats[i]) || mon_pcnt[i] !== 32'(k_pkts[i])) begin
               n_fail++;
               $display("FAIL counters inst%0d t=%0t: got beat=%0d pkt=%0d expected beat=%0d pkt=%0d",
                        i, $time, mon_bcnt[i], mon_pcnt[i], k_beats[i], k_pkts[i]);
            end
            if (prev_stall[i]) begin
               n_tests++;
               if (mon_data[i] !== prev_data[i] || mon_last[i] !== prev_last[i]) begin
                  n_fail++;
                  $display("FAIL stall_hold inst%0d t=%0t: got data=%0h last=%b expected data=%0h last=%b",
                           i, $time, mon_data[i], mon_last[i], prev_data[i], prev_last[i]);
               end
            end
            if (rst_n && mon_valid[i] === 1'b1 && m_tready) begin
               n_tests++;
               if (mon_data[i] !== exp_data(i, k_beats[i]) || mon_last[i] !== mlast) begin
                  n_fail++;
                  $display("FAIL beat inst%0d k=%0d: got data=%0h last=%b expected data=%0h last=%b",
                           i, k_beats[i], mon_data[i], mon_last[i], exp_data(i, k_beats[i]), mlast);
               end
            end
         end
         if (!rst_n) begin
            k_beats[i]    = 0;
            k_pkts[i]     = 0;
            exp_valid[i]  = 1'b0;
            exp_done[i]   = 1'b0;
            prev_stall[i] = 1'b0;
            gap_left[i]   = 0;
         end else if (mon_on) begin
            acc = (mon_valid[i] === 1'b1) && m_tready;
            exp_done[i] = acc && mlast;
            if (acc) begin
               k_beats[i]++;
               if (mlast) begin
                  k_pkts[i]++;
                  gap_left[i]  = P_GAP[i];
                  exp_valid[i] = (P_GAP[i] == 0) ? en : 1'b0;
               end else begin
                  exp_valid[i] = 1'b1;
               end
            end else if (mon_valid[i] === 1'b1) begin
               exp_valid[i] = 1'b1;
            end else begin
               exp_valid[i] = (gap_left[i] > 1) ? 1'b0 : en;
               if (gap_left[i] > 0) gap_left[i]--;
            end
            prev_stall[i] = (mon_valid[i] === 1'b1) && !m_tready;
            prev_data[i]  = mon_data[i];
            prev_last[i]  = mon_last[i];
         end
      end
      if (!rst_n) mon_on = 1'b1;
   endtask

   task automatic cycle();
      monitor();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; m_tready = 1'b1;
      cycle();
      cycle();
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (mon_valid[i] !== 1'b0 || mon_last[i] !== 1'b0 || mon_done[i] !== 1'b0 ||
             mon_bcnt[i] !== 32'd0 || mon_pcnt[i] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: got valid=%b last=%b done=%b beat=%0d pkt=%0d expected all zero",
                     i, mon_valid[i], mon_last[i], mon_done[i], mon_bcnt[i], mon_pcnt[i]);
         end
         n_tests++;
         if (mon_data[i] !== exp_data(i, 0)) begin
            n_fail++;
            $display("FAIL reset_data inst%0d: got %0h expected %0h", i, mon_data[i], exp_data(i, 0));
         end
      end
      rst_n = 1'b1; en = 1'b0;
   endtask

   task automatic test_stream();
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      int lasts[$];
      int n_done;
      int cyc;
      n_done = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      cycle();
      n_tests++;
      if (mon_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: got tvalid=%b expected 1 one cycle after en", mon_valid[0]);
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(16'(i));
      while (got_q.size() < 16 && cyc < 60) begin
         if (mon_valid[0] === 1'b1 && m_tready) begin
            if (mon_last[0] === 1'b1) lasts.push_back(got_q.size());
            got_q.push_back(mon_data[0]);
         end
         cycle();
         cyc++;
         if (mon_done[0] === 1'b1) n_done++;
      end
      n_tests++;
      if (got_q.size() != 16) begin
         n_fail++;
         $display("FAIL stream_beats: got %0d beats expected 16", got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL stream_data beat%0d: got %0h expected %0h", i, got_q[i], exp_q[i]);
         end
      end
      n_tests++;
      if (lasts.size() != 2 || lasts[0] != 7 || lasts[1] != 15) begin
         n_fail++;
         $display("FAIL stream_tlast: got %0d tlasts (first at %0d) expected beats 7 and 15",
                  lasts.size(), (lasts.size() > 0) ? lasts[0] : -1);
      end
      n_tests++;
      if (n_done != 2 || mon_bcnt[0] !== 32'd16 || mon_pcnt[0] !== 32'd2) begin
         n_fail++;
         $display("FAIL stream_counts: got done=%0d beat=%0d pkt=%0d expected 2 16 2", n_done, mon_bcnt[0], mon_pcnt[0]);
      end
      en = 1'b0;
   endtask

   task automatic test_stall();
      logic [15:0] got_q[$];
      int drops;
      int cyc;
      drops = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b0;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      cycle();
      while (got_q.size() < 8 && cyc < 60) begin
         m_tready = ~m_tready;
         if (mon_valid[0] !== 1'b1) drops++;
         if (mon_valid[0] === 1'b1 && m_tready) got_q.push_back(mon_data[0]);
         cycle();
         cyc++;
      end
      n_tests++;
      if (drops != 0 || got_q.size() != 8) begin
         n_fail++;
         $display("FAIL stall_valid: got drops=%0d beats=%0d expected 0 and 8", drops, got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         n_tests++;
         if (got_q[i] !== 16'(i)) begin
            n_fail++;
            $display("FAIL stall_data beat%0d: got %0h expected %0h", i, got_q[i], i);
         end
      end
      en = 1'b0; m_tready = 1'b1;
   endtask

   task automatic test_gap();
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      logic [15:0] data7;
      int cyc;
      cyc = 0; data7 = '0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      while (mon_valid[1] !== 1'b1 && cyc < 10) begin
         cycle();
         cyc++;
      end
      exp_q = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
      for (int c = 0; c < 11; c++) begin
         got_q.push_back({15'd0, mon_valid[1]});
         if (c == 7) data7 = mon_data[1];
         cycle();
      end
      for (int c = 0; c < 11; c++) begin
         n_tests++;
         if (got_q[c] !== exp_q[c]) begin
            n_fail++;
            $display("FAIL gap_valid cycle%0d: got %0d expected %0d", c, got_q[c], exp_q[c]);
         end
      end
      n_tests++;
      if (data7 !== 16'd4) begin
         n_fail++;
         $display("FAIL gap_next_data: got %0h expected 4", data7);
      end
      en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      int lasts[$];
      int cyc;
      cyc = 0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      exp_q = '{16'd14, 16'd15, 16'd0, 16'd1};
      while (got_q.size() < 4 && cyc < 20) begin
         if (mon_valid[2] === 1'b1) begin
            if (mon_last[2] === 1'b1) lasts.push_back(got_q.size());
            got_q.push_back(mon_data[2]);
         end
         cycle();
         cyc++;
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL wrap_data beat%0d: got %0h expected %0h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      n_tests++;
      if (lasts.size() != 1 || lasts[0] != 3) begin
         n_fail++;
         $display("FAIL wrap_tlast: got %0d tlasts expected one on beat 3", lasts.size());
      end
      en = 1'b0;
   endtask

   task automatic test_en_drop();
      int lasts[$];
      int n_acc;
      int idle_run;
      int cyc;
      n_acc = 0; idle_run = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      while (idle_run < 5 && cyc < 60) begin
         if (mon_valid[0] === 1'b1 && m_tready) begin
            if (mon_last[0] === 1'b1) lasts.push_back(n_acc);
            n_acc++;
         end
         idle_run = (mon_valid[0] === 1'b1 || n_acc == 0) ? 0 : idle_run + 1;
         cycle();
         cyc++;
         if (n_acc == 3) en = 1'b0;
      end
      n_tests++;
      if (n_acc != 8 || lasts.size() != 1 || lasts[0] != 7) begin
         n_fail++;
         $display("FAIL en_drop_packet: got %0d beats %0d tlasts expected 8 beats tlast on 7", n_acc, lasts.size());
      end
      n_tests++;
      if (mon_valid[0] !== 1'b0 || mon_pcnt[0] !== 32'd1 || mon_bcnt[0] !== 32'd8) begin
         n_fail++;
         $display("FAIL en_drop_idle: got valid=%b pkt=%0d beat=%0d expected 0 1 8", mon_valid[0], mon_pcnt[0], mon_bcnt[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got_q[$];
      int lasts[$];
      int n_pre;
      int cyc;
      n_pre = 0; cyc = 0;
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1; en = 1'b1;
      while (n_pre < 6 && cyc < 30) begin
         if (mon_valid[0] === 1'b1 && m_tready) n_pre++;
         cycle();
         cyc++;
      end
      rst_n = 1'b0;
      cycle();
      n_tests++;
      if (mon_valid[0] !== 1'b0 || mon_bcnt[0] !== 32'd0 || mon_pcnt[0] !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset_state: got valid=%b beat=%0d pkt=%0d expected 0 0 0", mon_valid[0], mon_bcnt[0], mon_pcnt[0]);
      end
      rst_n = 1'b1;
      cyc = 0;
      while (got_q.size() < 8 && cyc < 30) begin
         if (mon_valid[0] === 1'b1 && m_tready) begin
            if (mon_last[0] === 1'b1) lasts.push_back(got_q.size());
            got_q.push_back(mon_data[0]);
         end
         cycle();
         cyc++;
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (i >= got_q.size() || got_q[i] !== 16'(i)) begin
            n_fail++;
            $display("FAIL mid_reset_data beat%0d: got %0h expected %0h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, i);
         end
      end
      n_tests++;
      if (lasts.size() != 1 || lasts[0] != 7 || mon_pcnt[0] !== 32'd1) begin
         n_fail++;
         $display("FAIL mid_reset_tlast: got %0d tlasts pkt=%0d expected tlast on beat 7 pkt=1", lasts.size(), mon_pcnt[0]);
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      rst_n = 1'b0; en = 1'b1; m_tready = 1'b1;
      cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         m_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) en = ~en;
         rst_n = ($urandom_range(0, 199) != 0);
         cycle();
      end
      rst_n = 1'b1; en = 1'b0; m_tready = 1'b1;
      repeat (20) cycle();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; m_tready = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_gap();
      test_wrap();
      test_en_drop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
